// File: rtl/screen_writer_pkg.sv
// Shared definitions for the screen writer: FSM state encoding and the
// default screen RAM geometry.
package screen_writer_pkg;

    // Controller states; DRAIN and CLEAR exist only when the clear engine is built.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam int DEFAULT_ADDR_WIDTH = 16;
    localparam int DEFAULT_WIDTH      = 32;

endpackage

// File: rtl/screen_wr_fifo.sv
// Write-request FIFO for the screen writer. DEPTH must be a power of two
// (pointers wrap naturally); the head entry is visible combinationally.
module screen_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int               PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    // Store pushed entries.
    // NOTE: storage has no reset; count guarantees a slot is written before it is ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Track pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);

endmodule

// File: rtl/screen_writer.sv
// Screen writer: queues CPU pixel writes and replays them onto a registered
// screen RAM write port. Optional clear engine (define SCREEN_WRITER_CLEAR_EN)
// drains pending writes, then fills CLEAR_WORDS words with a latched colour.
module screen_writer
    import screen_writer_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int DEPTH       = 4,
    parameter int CLEAR_WORDS = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0]      req_data,
    input  logic                  clr_start,
    input  logic [WIDTH-1:0]      clr_color,
    output logic                  busy,
    output logic                  clr_done,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [WIDTH-1:0]      ram_wdata
);
    localparam int ENTRY_W = ADDR_WIDTH + WIDTH;

    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    head;

    // Clear-engine interface to the write port (constant when the engine is absent).
    logic                  clr_issue;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [WIDTH-1:0]      clr_wdata;
    logic                  clr_done_next;
    logic                  engine_active;

    assign push = req_valid && req_ready;

    screen_wr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({req_addr, req_data}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef SCREEN_WRITER_CLEAR_EN
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(CLEAR_WORDS - 1);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [WIDTH-1:0]      clr_color_q;
    logic                  clr_last;
    logic                  clr_last_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next state: IDLE -> DRAIN on clr_start, DRAIN -> CLEAR once empty, CLEAR -> IDLE after last word.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clr_start)             state_next = DRAIN;
            DRAIN:   if (fifo_empty)            state_next = CLEAR;
            CLEAR:   if (clr_cnt == LAST_WORD)  state_next = IDLE;
            default:                            state_next = IDLE;
        endcase
    end

    // State outputs: accept and pop in IDLE, keep popping in DRAIN, issue fill words in CLEAR.
    always_comb begin
        req_ready = 1'b0;
        pop       = 1'b0;
        clr_issue = 1'b0;
        clr_last  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !fifo_full;
                pop       = !fifo_empty;
            end
            DRAIN: pop = !fifo_empty;
            CLEAR: begin
                clr_issue = 1'b1;
                clr_last  = (clr_cnt == LAST_WORD);
            end
            default: ;
        endcase
    end

    // Latch the fill colour, run the clear address counter (holds at the last word, never wraps).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_cnt     <= '0;
            clr_color_q <= '0;
            clr_last_q  <= 1'b0;
        end else begin
            clr_last_q <= clr_last;
            if (state == IDLE && clr_start) clr_color_q <= clr_color;
            if (state == DRAIN)                clr_cnt <= '0;
            else if (clr_issue && !clr_last)   clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
        end
    end

    assign clr_addr      = clr_cnt;
    assign clr_wdata     = clr_color_q;
    assign clr_done_next = clr_last_q;
    assign engine_active = (state != IDLE);
`else
    logic unused_clr;

    assign req_ready     = !fifo_full;
    assign pop           = !fifo_empty;
    assign clr_issue     = 1'b0;
    assign clr_addr      = '0;
    assign clr_wdata     = '0;
    assign clr_done_next = 1'b0;
    assign engine_active = 1'b0;
    assign unused_clr    = ^{clr_start, clr_color};
`endif

    // Registered RAM write port: a FIFO pop or a clear word, never both in one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            clr_done  <= 1'b0;
        end else begin
            ram_we   <= pop || clr_issue;
            clr_done <= clr_done_next;
            if (pop) begin
                ram_addr  <= head[ENTRY_W-1:WIDTH];
                ram_wdata <= head[WIDTH-1:0];
            end else if (clr_issue) begin
                ram_addr  <= clr_addr;
                ram_wdata <= clr_wdata;
            end
        end
    end

    assign busy = engine_active || !fifo_empty || ram_we;

endmodule

// File: tb/tb_screen_writer.sv
// Self-checking bench for screen_writer. A transaction-level model predicts the
// ordered list of RAM writes, the clr_done pulse and req_ready; a compare
// process checks them every cycle, directed tests add literal expectations.
// Clear-engine tests run when SCREEN_WRITER_CLEAR_EN is defined.
module tb_screen_writer;

    localparam int AW          = 16;
    localparam int DW          = 32;
    localparam int CLEAR_WORDS = 8;
`ifdef SCREEN_WRITER_CLEAR_EN
    localparam bit CLEAR_BUILT = 1'b1;
`else
    localparam bit CLEAR_BUILT = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          clr_start;
    logic [DW-1:0] clr_color;
    logic          busy;
    logic          clr_done;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;

    screen_writer #(
        .ADDR_WIDTH  (AW),
        .WIDTH       (DW),
        .DEPTH       (4),
        .CLEAR_WORDS (CLEAR_WORDS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .clr_start (clr_start),
        .clr_color (clr_color),
        .busy      (busy),
        .clr_done  (clr_done),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            is_clear;
        bit            last;
    } exp_t;

    exp_t                 exp_q[$];
    logic [AW+DW-1:0]     we_log[$];
    bit                   model_clearing;
    bit                   done_due;
    int                   n_checks;
    int                   n_fails;
    int                   we_count;
    int                   clr_we_count;
    int                   done_count;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_test();
        we_count     = 0;
        clr_we_count = 0;
        done_count   = 0;
        we_log.delete();
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0 || model_clearing) && n < max_cycles) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, (n < max_cycles) ? 64'd1 : 64'd0, 64'd1);
        repeat (2) tick();
    endtask

    // Model + compare: one pass per cycle at the falling edge.
    always @(negedge clk) begin : compare
        exp_t e;
        bit   saw_last;
        saw_last = 1'b0;
        if (!rst) begin
            exp_q.delete();
            model_clearing = 1'b0;
            done_due       = 1'b0;
        end else begin
            if (ram_we) begin
                we_count++;
                we_log.push_back({ram_addr, ram_wdata});
                if (exp_q.size() == 0) begin
                    check("unexpected_ram_we", {63'd0, ram_we}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ram_write", {16'd0, ram_addr, ram_wdata}, {16'd0, e.addr, e.data});
                    if (e.is_clear) clr_we_count++;
                    saw_last = e.last;
                end
            end
            if (clr_done) done_count++;
            check("clr_done", {63'd0, clr_done}, {63'd0, done_due});
            done_due = saw_last;
            if (saw_last) model_clearing = 1'b0;
            check("req_ready", {63'd0, req_ready}, {63'd0, !model_clearing});
            if (req_valid && !model_clearing) begin
                e.addr = req_addr; e.data = req_data; e.is_clear = 1'b0; e.last = 1'b0;
                exp_q.push_back(e);
            end
            if (CLEAR_BUILT && clr_start && !model_clearing) begin
                model_clearing = 1'b1;
                for (int k = 0; k < CLEAR_WORDS; k++) begin
                    e.addr = AW'(k); e.data = clr_color; e.is_clear = 1'b1;
                    e.last = (k == CLEAR_WORDS - 1);
                    exp_q.push_back(e);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0;
        clr_start = 1'b0; clr_color = '0;
        n_checks = 0; n_fails = 0;
        start_test();

        // Reset state
        repeat (2) tick();
        check("rst_ram_we",    {63'd0, ram_we},   64'd0);
        check("rst_ram_addr",  {48'd0, ram_addr}, 64'd0);
        check("rst_ram_wdata", {32'd0, ram_wdata}, 64'd0);
        check("rst_clr_done",  {63'd0, clr_done}, 64'd0);
        check("rst_busy",      {63'd0, busy},     64'd0);
        rst = 1'b1;
        check("post_rst_ready", {63'd0, req_ready}, 64'd1);
        check("post_rst_busy",  {63'd0, busy},      64'd0);
        tick();

        // Single write: ram_we exactly two cycles after req_valid is presented
        start_test();
        req_valid = 1'b1; req_addr = 16'h0010; req_data = 32'h0000_0FFF;
        tick();
        req_valid = 1'b0;
        check("single_lat1_we", {63'd0, ram_we}, 64'd0);
        tick();
        check("single_we",   {63'd0, ram_we},    64'd1);
        check("single_addr", {48'd0, ram_addr},  64'h0010);
        check("single_data", {32'd0, ram_wdata}, 64'h0000_0FFF);
        tick();
        check("single_we_off", {63'd0, ram_we}, 64'd0);
        wait_idle("single", 20);
        check("single_count", 64'(we_count), 64'd1);

        // Burst of 6 with req_valid held: ready stays high, writes back-to-back in order
        start_test();
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            req_addr  = AW'(16'h0100 + i);
            req_data  = DW'(32'hA5A5_0000 + i);
            check("burst_ready", {63'd0, req_ready}, 64'd1);
            check("burst_we", {63'd0, ram_we}, (i >= 2) ? 64'd1 : 64'd0);
            tick();
        end
        req_valid = 1'b0;
        check("burst_tail0", {47'd0, ram_we, ram_addr}, {47'd0, 1'b1, 16'h0104});
        tick();
        check("burst_tail1", {47'd0, ram_we, ram_addr}, {47'd0, 1'b1, 16'h0105});
        tick();
        check("burst_tail_off", {63'd0, ram_we}, 64'd0);
        wait_idle("burst", 20);
        check("burst_count", 64'(we_count), 64'd6);
        check("burst_first", {16'd0, we_log[0]}, {16'd0, 16'h0100, 32'hA5A5_0000});
        check("burst_last",  {16'd0, we_log[5]}, {16'd0, 16'h0105, 32'hA5A5_0005});

`ifdef SCREEN_WRITER_CLEAR_EN
        // Two queued writes, then clear with colour 0xF
        start_test();
        send(16'h0020, 32'h0000_0011);
        send(16'h0021, 32'h0000_0022);
        clr_start = 1'b1; clr_color = 32'h0000_000F;
        tick();
        clr_start = 1'b0; clr_color = '0;
        check("clr_ready_low", {63'd0, req_ready}, 64'd0);
        check("clr_busy",      {63'd0, busy},      64'd1);
        wait_idle("clr", 60);
        check("clr_total",  64'(we_count),     64'd10);
        check("clr_words",  64'(clr_we_count), 64'd8);
        check("clr_pulses", 64'(done_count),   64'd1);
        check("clr_log0", {16'd0, we_log[0]}, {16'd0, 16'h0020, 32'h0000_0011});
        check("clr_log1", {16'd0, we_log[1]}, {16'd0, 16'h0021, 32'h0000_0022});
        check("clr_log2", {16'd0, we_log[2]}, {16'd0, 16'h0000, 32'h0000_000F});
        check("clr_log9", {16'd0, we_log[9]}, {16'd0, 16'h0007, 32'h0000_000F});
        check("clr_ready_back", {63'd0, req_ready}, 64'd1);

        // Request in the clr_start cycle is written first; repeated clr_start and
        // requests during the clear are ignored
        start_test();
        send(16'h0040, 32'h0000_00AA);
        req_valid = 1'b1; req_addr = 16'h0041; req_data = 32'h0000_00BB;
        clr_start = 1'b1; clr_color = 32'h0000_003C;
        tick();
        req_valid = 1'b0; clr_start = 1'b0;
        repeat (4) tick();
        clr_start = 1'b1; clr_color = 32'h0000_DEAD;
        req_valid = 1'b1; req_addr = 16'h0DEA; req_data = 32'h0000_1234;
        repeat (3) tick();
        clr_start = 1'b0; req_valid = 1'b0;
        wait_idle("reclr", 60);
        check("reclr_total",  64'(we_count),     64'd10);
        check("reclr_words",  64'(clr_we_count), 64'd8);
        check("reclr_pulses", 64'(done_count),   64'd1);
        check("reclr_log1", {16'd0, we_log[1]}, {16'd0, 16'h0041, 32'h0000_00BB});
        check("reclr_log2", {16'd0, we_log[2]}, {16'd0, 16'h0000, 32'h0000_003C});
        check("reclr_log9", {16'd0, we_log[9]}, {16'd0, 16'h0007, 32'h0000_003C});

        // Reset asserted at the third clear write
        start_test();
        clr_start = 1'b1; clr_color = 32'h0000_0077;
        tick();
        clr_start = 1'b0;
        begin
            int n;
            n = 0;
            while (!(ram_we && ram_addr == 16'd2) && n < 40) begin
                tick();
                n++;
            end
            check("rst_mid_third_write_seen", (n < 40) ? 64'd1 : 64'd0, 64'd1);
        end
        rst = 1'b0;
        #1;
        check("rst_mid_we",    {63'd0, ram_we},    64'd0);
        check("rst_mid_addr",  {48'd0, ram_addr},  64'd0);
        check("rst_mid_wdata", {32'd0, ram_wdata}, 64'd0);
        check("rst_mid_busy",  {63'd0, busy},      64'd0);
        repeat (2) tick();
        rst = 1'b1;
        check("rst_mid_ready", {63'd0, req_ready}, 64'd1);
        check("rst_mid_idle",  {63'd0, busy},      64'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rst_mid_no_we", {63'd0, ram_we}, 64'd0);
        end
        check("rst_mid_writes", 64'(we_count),   64'd2);
        check("rst_mid_done",   64'(done_count), 64'd0);
`else
        // Clear engine absent: clr_start is ignored, the same-cycle request still lands
        start_test();
        req_valid = 1'b1; req_addr = 16'h0030; req_data = 32'h0000_0055;
        clr_start = 1'b1; clr_color = 32'h0000_0099;
        tick();
        req_valid = 1'b0;
        check("noclr_ready", {63'd0, req_ready}, 64'd1);
        repeat (3) tick();
        clr_start = 1'b0;
        wait_idle("noclr", 30);
        check("noclr_writes", 64'(we_count),   64'd1);
        check("noclr_done",   64'(done_count), 64'd0);
        check("noclr_log0", {16'd0, we_log[0]}, {16'd0, 16'h0030, 32'h0000_0055});
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/screen_writer.md
SCREEN_WRITER -- requirements
Module: screen_writer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16: screen RAM word-address width.
REQ-002 SHALL have parameter WIDTH, default 32: screen RAM data width.
REQ-003 SHALL have parameter DEPTH, default 4: write-request FIFO depth, power of two, at least 2.
REQ-004 SHALL have parameter CLEAR_WORDS, default 2**ADDR_WIDTH: number of words written by a clear.
REQ-005 SHALL have port clk  in  1: single clock.
REQ-006 SHALL have port rst  in  1: reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid  in  1: CPU pixel-write request.
REQ-008 SHALL have port req_ready  out  1: request can be accepted this cycle.
REQ-009 SHALL have port req_addr  in  ADDR_WIDTH: target word address.
REQ-010 SHALL have port req_data  in  WIDTH: colour word.
REQ-011 SHALL have port clr_start  in  1: single-cycle clear-screen request.
REQ-012 SHALL have port clr_color  in  WIDTH: fill word, sampled together with clr_start.
REQ-013 SHALL have port busy  out  1: FIFO non-empty or a clear is in progress.
REQ-014 SHALL have port clr_done  out  1: one-cycle pulse after the last clear write.
REQ-015 SHALL have port ram_we  out  1: screen RAM write enable.
REQ-016 SHALL have port ram_addr  out  ADDR_WIDTH: screen RAM write address.
REQ-017 SHALL have port ram_wdata  out  WIDTH: screen RAM write data.

Function
REQ-018 SHALL accept a request on a rising clk edge where req_valid && req_ready, pushing {req_addr, req_data} into the FIFO.
REQ-019 SHALL drive req_ready = !fifo_full && state==IDLE, combinationally from registered state.
REQ-020 SHALL pop at most one FIFO entry per cycle in IDLE and present it registered: ram_we=1, ram_addr, ram_wdata on the following cycle; minimum latency from accept to ram_we is 2 cycles when the FIFO is empty.
REQ-021 SHALL allow push and pop in the same cycle, leaving occupancy unchanged; a push is never attempted while the FIFO is full.
REQ-022 SHALL write entries to RAM in acceptance order; back-to-back accepts SHALL produce back-to-back ram_we cycles.
REQ-023 SHALL implement FSM states IDLE, DRAIN, CLEAR.
REQ-024 On clr_start in IDLE: latch clr_color and go to DRAIN; req_ready=0 from the next cycle.
REQ-025 DRAIN SHALL keep popping the FIFO one entry per cycle; when the FIFO is empty, go to CLEAR with the counter at 0.
REQ-026 CLEAR SHALL issue ram_we for addresses 0..CLEAR_WORDS-1, one per cycle, with ram_wdata equal to the latched colour.
REQ-027 After the last CLEAR write (address CLEAR_WORDS-1), the FSM SHALL pulse clr_done for one cycle and return to IDLE; the counter SHALL not wrap.
REQ-028 SHALL ignore clr_start outside IDLE.
REQ-029 If clr_start and an accepted request occur in the same IDLE cycle, the request SHALL be queued and written before the clear.
REQ-030 SHALL drive busy = (state!=IDLE) || fifo_not_empty || ram_we.

Reset
REQ-031 SHALL, while rst=0, asynchronously force the FSM to IDLE, empty the FIFO, and zero the counter and latched colour.
REQ-032 SHALL hold ram_we=0, ram_addr=0, ram_wdata=0, clr_done=0 and busy=0 during reset, with req_ready=1 after release.
REQ-033 Reset asserted mid-clear or mid-drain SHALL abandon all pending writes; no ram_we SHALL occur in the first cycle after release.

Configuration
REQ-034 SHALL compile the clear engine only when macro SCREEN_WRITER_CLEAR_EN is defined.
REQ-035 Without SCREEN_WRITER_CLEAR_EN: the DRAIN and CLEAR states SHALL be absent, clr_start and clr_color SHALL be ignored, clr_done SHALL be tied to 0, and req_ready = !fifo_full.

Structure
REQ-036 The shared package SHALL hold the FSM state enum (IDLE, DRAIN, CLEAR) and the default ADDR_WIDTH and WIDTH constants.
REQ-037 The FIFO SHALL be a sub-module named screen_wr_fifo (parameters DEPTH and entry width; push/pop/full/empty).

Verification
REQ-038 Single write: accept addr=0x0010, data=0x00000FFF -> exactly one ram_we cycle 2 cycles later with the same addr and data.
REQ-039 Burst: req_valid held for 6 requests with DEPTH=4 and no RAM stall -> req_ready stays 1; 6 consecutive ram_we cycles in order.
REQ-040 Clear with CLEAR_WORDS=8: two requests are queued, then clr_start with clr_color=0x0000000F -> the two writes happen first, then addresses 0..7 are written with 0xF; clr_done pulses once; req_ready=0 throughout.
REQ-041 clr_start is repeated during CLEAR -> it is ignored; exactly 8 clear writes occur.
REQ-042 rst pulsed low at the 3rd clear write -> all outputs read 0 immediately; after release state is IDLE, busy=0, and no further ram_we occurs.
REQ-043 Build without SCREEN_WRITER_CLEAR_EN: clr_start is pulsed -> no clear writes occur, and clr_done stays 0.
